// File: rtl/fsm_trigger_seq.sv
// -----------------------------------------------------------------------------
// fsm_trigger_seq
//
// Initiator side of the trigger/done handshake used by the counting fsm.
// A sequence, launched by start, issues NUM_RUNS single-cycle trigger pulses
// to a downstream timer fsm. Each trigger is followed by a wait for its done
// response, guarded by a watchdog. Consecutive runs are separated by GAP idle
// cycles. Status is reported to the board top / LED logic.
//
// Parameters
//   NUM_RUNS  trigger/done exchanges per start (1..127)
//   TIMEOUT   max cycles spent waiting for done before error (1..127)
//   GAP       idle cycles between a done and the next trigger (0 allowed)
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous reset, active low
//   en           in   global enable; low pauses the wait/gap counters
//   start        in   request a sequence; honoured only in IDLE or ERR
//   done         in   completion from the downstream fsm; honoured only in WAIT
//   trigger      out  single-cycle start pulse to the downstream fsm
//   busy         out  high while a sequence is in progress
//   finished     out  one-cycle pulse when all NUM_RUNS exchanges complete
//   timeout_err  out  sticky watchdog error, cleared by the next accepted start
//   run_count    out  completed exchanges in the current sequence
// -----------------------------------------------------------------------------
module fsm_trigger_seq #(
  parameter logic [6:0] NUM_RUNS = 7'd4,
  parameter logic [6:0] TIMEOUT  = 7'd64,
  parameter logic [6:0] GAP      = 7'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       start,
  input  logic       done,
  output logic       trigger,
  output logic       busy,
  output logic       finished,
  output logic       timeout_err,
  output logic [6:0] run_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRE,
    S_WAIT,
    S_GAP,
    S_FINISH,
    S_ERR
  } state_t;

  // Terminal counts. GAP_LAST is only used when GAP != 0, so its wrap at
  // GAP == 0 is never observed.
  localparam logic [6:0] TIMEOUT_LAST = TIMEOUT - 7'd1;
  localparam logic [6:0] GAP_LAST     = GAP - 7'd1;

  state_t     state;
  state_t     state_nxt;
  logic [6:0] wait_cnt;
  logic [6:0] gap_cnt;
  logic [6:0] run_count_inc;

  assign run_count_inc = run_count + 7'd1;

  // Next-state decode. It is used both to advance the state register and to
  // load the output flops, so every output is a plain flop (glitch-free) that
  // lines up exactly with the state it describes.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE, S_ERR: begin
        if (start && en) state_nxt = S_FIRE;
      end
      S_FIRE: begin
        // One cycle regardless of en: trigger can never stretch.
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // done wins over the watchdog, and is honoured even while paused.
        if (done) begin
          if (run_count_inc == NUM_RUNS) state_nxt = S_FINISH;
          else if (GAP == 7'd0)          state_nxt = S_FIRE;
          else                           state_nxt = S_GAP;
        end else if (en && (wait_cnt == TIMEOUT_LAST)) begin
          state_nxt = S_ERR;
        end
      end
      S_GAP: begin
        if (en && (gap_cnt == GAP_LAST)) state_nxt = S_FIRE;
      end
      S_FINISH: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: the reset branch is asynchronous (rst_n is in the sensitivity list),
  // so an abort mid-sequence clears every output without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      trigger     <= 1'b0;
      busy        <= 1'b0;
      finished    <= 1'b0;
      timeout_err <= 1'b0;
      run_count   <= 7'd0;
      wait_cnt    <= 7'd0;
      gap_cnt     <= 7'd0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every flop here samples
      // the pre-edge values and the order of the statements does not matter.
      state       <= state_nxt;
      trigger     <= (state_nxt == S_FIRE);
      busy        <= (state_nxt inside {S_FIRE, S_WAIT, S_GAP, S_FINISH});
      finished    <= (state_nxt == S_FINISH);
      // ERR is only left through an accepted start, which makes this sticky.
      timeout_err <= (state_nxt == S_ERR);

      case (state)
        S_IDLE, S_ERR: begin
          if (start && en) run_count <= 7'd0;
        end
        S_FIRE: begin
          wait_cnt <= 7'd0;
        end
        S_WAIT: begin
          if (done) begin
            run_count <= run_count_inc;
            gap_cnt   <= 7'd0;
          end else if (en) begin
            wait_cnt <= wait_cnt + 7'd1;
          end
        end
        S_GAP: begin
          if (en) gap_cnt <= gap_cnt + 7'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_trigger_seq.sv
// -----------------------------------------------------------------------------
// tb_fsm_trigger_seq
//
// Scoreboard bench for fsm_trigger_seq with NUM_RUNS=2, TIMEOUT=40, GAP=3.
// The stimulus process pushes every expected change of the output vector
// {trigger, busy, finished, timeout_err, run_count}, tagged with the cycle in
// which it must appear, plus a few "hold" snapshots. A monitor process samples
// the outputs on each falling edge and pops/compares whenever the vector
// changes or a queued entry comes due. A behavioural responder returns a
// one-cycle done resp_delay cycles after each trigger it sees.
//
// Cycle numbering: cyc counts rising edges; a value driven on the falling edge
// of cycle c is sampled on the next rising edge, so its effect shows in c+1.
// -----------------------------------------------------------------------------
module tb_fsm_trigger_seq;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic       start = 1'b0;
  logic       done  = 1'b0;
  logic       trigger;
  logic       busy;
  logic       finished;
  logic       timeout_err;
  logic [6:0] run_count;

  int cyc     = 0;
  int n_vec   = 0;
  int n_err   = 0;

  // Responder controls (written by the stimulus, read by the responder).
  bit resp_on    = 1'b0;
  int resp_delay = 1;

  typedef struct {
    int          cyc;
    logic [10:0] vec;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  fsm_trigger_seq #(
    .NUM_RUNS (7'd2),
    .TIMEOUT  (7'd40),
    .GAP      (7'd3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .start       (start),
    .done        (done),
    .trigger     (trigger),
    .busy        (busy),
    .finished    (finished),
    .timeout_err (timeout_err),
    .run_count   (run_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [10:0] out_vec();
    return {trigger, busy, finished, timeout_err, run_count};
  endfunction

  function automatic void push(int cy, logic t, logic b, logic f, logic e,
                               logic [6:0] rc, string nm);
    exp_t x;
    x.cyc  = cy;
    x.vec  = {t, b, f, e, rc};
    x.name = nm;
    exp_q.push_back(x);
  endfunction

  task automatic check(string name, logic [10:0] got, logic [10:0] exp_v,
                       int got_c, int exp_c);
    n_vec++;
    if (got !== exp_v || got_c != exp_c) begin
      n_err++;
      $display("FAIL %s: got trig/busy/fin/terr/rc=%b/%b/%b/%b/%0d at cycle %0d, expected %b/%b/%b/%b/%0d at cycle %0d",
               name, got[10], got[9], got[8], got[7], got[6:0], got_c,
               exp_v[10], exp_v[9], exp_v[8], exp_v[7], exp_v[6:0], exp_c);
    end
  endtask

  task automatic go_to(int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Responder: one-cycle done, resp_delay cycles after a trigger cycle.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) done = 1'b1;
      end
      if (trigger === 1'b1 && resp_on) cnt = resp_delay;
    end
  end

  // Monitor: pops on every output change, or when a queued entry comes due.
  initial begin
    logic [10:0] prev;
    logic [10:0] cur;
    exp_t        e;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = out_vec();
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_change: outputs became %b at cycle %0d, expected no change",
                   cur, cyc);
        end else begin
          e = exp_q.pop_front();
          check(e.name, cur, e.vec, cyc, e.cyc);
        end
        prev = cur;
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        check(e.name, cur, e.vec, cyc, e.cyc);
      end
    end
  end

  initial begin
    int c;
    int c2;

    // 1. Reset: outputs stay 0 while held and after release with start=0.
    push(2,  0, 0, 0, 0, 7'd0, "reset_hold");
    push(17, 0, 0, 0, 0, 7'd0, "reset_idle");
    go_to(2);
    rst_n = 1'b1;
    en    = 1'b1;
    go_to(20);

    // 2. Nominal, D=21: two runs, gap of 3, finished then idle with run_count=2.
    c = cyc;
    resp_on = 1'b1; resp_delay = 21;
    push(c+1,  1, 1, 0, 0, 7'd0, "nom_trig1");
    push(c+2,  0, 1, 0, 0, 7'd0, "nom_wait1");
    push(c+23, 0, 1, 0, 0, 7'd1, "nom_done1");
    push(c+26, 1, 1, 0, 0, 7'd1, "nom_trig2");
    push(c+27, 0, 1, 0, 0, 7'd1, "nom_wait2");
    push(c+48, 0, 1, 1, 0, 7'd2, "nom_finished");
    push(c+49, 0, 0, 0, 0, 7'd2, "nom_busy_fall");
    push(c+55, 0, 0, 0, 0, 7'd2, "nom_idle_hold");
    start = 1'b1;
    go_to(c+1);
    start = 1'b0;
    go_to(c+56);

    // 3. Timeout: silent responder -> ERR after 40 WAIT cycles; then restart
    //    from ERR with the minimum latency D=1 (done in the first WAIT cycle).
    c = cyc;
    resp_on = 1'b0;
    push(c+1,  1, 1, 0, 0, 7'd0, "to_trig");
    push(c+2,  0, 1, 0, 0, 7'd0, "to_wait");
    push(c+42, 0, 0, 0, 1, 7'd0, "to_err");
    push(c+45, 0, 0, 0, 1, 7'd0, "to_err_hold");
    start = 1'b1;
    go_to(c+1);
    start = 1'b0;
    go_to(c+50);
    c2 = cyc;
    resp_on = 1'b1; resp_delay = 1;
    push(c2+1, 1, 1, 0, 0, 7'd0, "restart_trig1");
    push(c2+2, 0, 1, 0, 0, 7'd0, "restart_wait1");
    push(c2+3, 0, 1, 0, 0, 7'd1, "restart_done1");
    push(c2+6, 1, 1, 0, 0, 7'd1, "restart_trig2");
    push(c2+7, 0, 1, 0, 0, 7'd1, "restart_wait2");
    push(c2+8, 0, 1, 1, 0, 7'd2, "restart_finished");
    push(c2+9, 0, 0, 0, 0, 7'd2, "restart_idle");
    start = 1'b1;
    go_to(c2+1);
    start = 1'b0;
    go_to(c2+15);

    // 4. Boundary, D=40: done arrives in the cycle wait_cnt == 39.
    c = cyc;
    resp_delay = 40;
    push(c+1,  1, 1, 0, 0, 7'd0, "bnd_trig1");
    push(c+2,  0, 1, 0, 0, 7'd0, "bnd_wait1");
    push(c+42, 0, 1, 0, 0, 7'd1, "bnd_done1");
    push(c+45, 1, 1, 0, 0, 7'd1, "bnd_trig2");
    push(c+46, 0, 1, 0, 0, 7'd1, "bnd_wait2");
    push(c+86, 0, 1, 1, 0, 7'd2, "bnd_finished");
    push(c+87, 0, 0, 0, 0, 7'd2, "bnd_idle");
    start = 1'b1;
    go_to(c+1);
    start = 1'b0;
    go_to(c+92);

    // 5. Pause, D=21: en low 10 cycles in WAIT and 10 cycles in GAP; the
    //    second trigger slips by 10 cycles. Then start with en=0 is ignored.
    c = cyc;
    resp_delay = 21;
    push(c+1,  1, 1, 0, 0, 7'd0, "pause_trig1");
    push(c+2,  0, 1, 0, 0, 7'd0, "pause_wait1");
    push(c+23, 0, 1, 0, 0, 7'd1, "pause_done1");
    push(c+36, 1, 1, 0, 0, 7'd1, "pause_trig2_delayed");
    push(c+37, 0, 1, 0, 0, 7'd1, "pause_wait2");
    push(c+58, 0, 1, 1, 0, 7'd2, "pause_finished");
    push(c+59, 0, 0, 0, 0, 7'd2, "pause_idle");
    push(c+70, 0, 0, 0, 0, 7'd2, "start_while_disabled");
    start = 1'b1;
    go_to(c+1);
    start = 1'b0;
    go_to(c+5);
    en = 1'b0;
    go_to(c+15);
    en = 1'b1;
    go_to(c+24);
    en = 1'b0;
    go_to(c+34);
    en = 1'b1;
    go_to(c+65);
    en    = 1'b0;
    start = 1'b1;
    go_to(c+66);
    start = 1'b0;
    en    = 1'b1;
    go_to(c+72);

    // 5b. Pause keeps the watchdog off: D=45 completes with a 10-cycle WAIT
    //     pause; the unpaused second run times out holding run_count=1.
    c = cyc;
    resp_delay = 45;
    push(c+1,   1, 1, 0, 0, 7'd0, "wdog_trig1");
    push(c+2,   0, 1, 0, 0, 7'd0, "wdog_wait1");
    push(c+47,  0, 1, 0, 0, 7'd1, "wdog_paused_done1");
    push(c+50,  1, 1, 0, 0, 7'd1, "wdog_trig2");
    push(c+51,  0, 1, 0, 0, 7'd1, "wdog_wait2");
    push(c+91,  0, 0, 0, 1, 7'd1, "wdog_err_run1");
    push(c+100, 0, 0, 0, 1, 7'd1, "wdog_late_done_ignored");
    start = 1'b1;
    go_to(c+1);
    start = 1'b0;
    go_to(c+5);
    en = 1'b0;
    go_to(c+15);
    en = 1'b1;
    go_to(c+101);

    // 6. Abort: start from ERR, then rst_n low mid-WAIT between clock edges.
    c = cyc;
    resp_delay = 21;
    push(c+1,  1, 1, 0, 0, 7'd0, "abort_trig");
    push(c+2,  0, 1, 0, 0, 7'd0, "abort_wait");
    push(c+11, 0, 0, 0, 0, 7'd0, "abort_cleared");
    push(c+30, 0, 0, 0, 0, 7'd0, "abort_late_done_ignored");
    start = 1'b1;
    go_to(c+1);
    start = 1'b0;
    go_to(c+10);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_async", out_vec(), 11'd0, cyc, c+10);
    go_to(c+12);
    rst_n = 1'b1;
    go_to(c+32);

    // Every queued expectation must have been consumed.
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0 (next '%s' at cycle %0d)",
               exp_q.size(), exp_q[0].name, exp_q[0].cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
